// File: rtl/comma_aligner.sv
// K28.5 comma search and 10-bit symbol alignment for the PCIe PHY receive path.
// Locks after LOCK_CNT in-phase commas and drops lock after UNLOCK_CNT off-phase commas.
module comma_aligner #(
  parameter int LOCK_CNT   = 2,
  parameter int UNLOCK_CNT = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ENB,
  input  logic       in_serial,
  output logic [9:0] out_10b,
  output logic       valid,
  output logic       locked
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  state_t     state, state_nxt;
  logic [9:0] sr, sr_nxt, nsr, out_nxt;
  logic [3:0] bit_cnt, bit_nxt, good_cnt, good_nxt, miss_cnt, miss_nxt;
  logic       valid_nxt, comma, boundary;

  assign nsr      = {in_serial, sr[9:1]};
  assign comma    = (nsr == K28_5_RDN) || (nsr == K28_5_RDP);
  assign boundary = (bit_cnt == 4'd9);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      sr       <= '0;
      out_10b  <= '0;
      valid    <= 1'b0;
      bit_cnt  <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      out_10b  <= out_nxt;
      valid    <= valid_nxt;
      bit_cnt  <= bit_nxt;
      good_cnt <= good_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    out_nxt   = out_10b;
    valid_nxt = 1'b0;
    bit_nxt   = bit_cnt;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    if (ENB) begin
      sr_nxt  = nsr;
      bit_nxt = boundary ? 4'd0 : bit_cnt + 4'd1;
      unique case (state)
        SEARCH: if (comma) begin
          bit_nxt   = 4'd0;
          good_nxt  = 4'd1;
          miss_nxt  = 4'd0;
          state_nxt = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
        end
        VERIFY: if (comma) begin
          if (boundary) begin
            good_nxt = good_cnt + 4'd1;
            // The symbol completing the lock count is itself emitted.
            if (good_cnt + 4'd1 >= LOCK_N) begin
              state_nxt = LOCKED;
              miss_nxt  = 4'd0;
              valid_nxt = 1'b1;
              out_nxt   = nsr;
            end
          end else begin
            bit_nxt  = 4'd0;
            good_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (boundary) begin
            valid_nxt = 1'b1;
            out_nxt   = nsr;
            if (comma) miss_nxt = 4'd0;
          end else if (comma) begin
            if (miss_cnt + 4'd1 >= UNLOCK_N) begin
              // Adopt the offending comma as the new symbol phase.
              miss_nxt  = 4'd0;
              bit_nxt   = 4'd0;
              good_nxt  = 4'd1;
              state_nxt = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
            end else begin
              miss_nxt = miss_cnt + 4'd1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: lock, re-phase, loss of lock, ENB gating, async reset.
module tb_comma_aligner;

  logic       CLK = 1'b0;
  logic       reset, ENB, in_serial;
  logic [9:0] out_10b;
  logic       valid, locked;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   vcnt;
  logic vlast;

  comma_aligner #(.LOCK_CNT(2), .UNLOCK_CNT(2)) dut (
    .CLK(CLK), .reset(reset), .ENB(ENB), .in_serial(in_serial),
    .out_10b(out_10b), .valid(valid), .locked(locked)
  );

  always #5 CLK = ~CLK;

  task automatic send_bit(input logic b);
    in_serial = b;
    ENB = 1'b1;
    @(posedge CLK);
    #1;
    if (valid) vcnt++;
    vlast = valid;
  endtask

  task automatic send_sym(input logic [9:0] s);
    vcnt = 0;
    for (int i = 0; i < 10; i++) send_bit(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0; ENB = 1'b0; in_serial = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_serial = 1'($urandom);
      ENB = 1'b1;
      @(posedge CLK);
      #1;
      n_tests++;
      if ({out_10b, valid, locked} !== 12'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: out=%h valid=%b locked=%b, want 0/0/0", i, out_10b, valid, locked);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_sym(10'h0AA);
      n_tests++;
      if (vcnt !== 0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release sym%0d: vcnt=%0d locked=%b, want 0/0", i, vcnt, locked);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    vcnt = 0;
    repeat (3) send_bit(1'b0);
    send_sym(10'h17C);
    n_tests++;
    if (vcnt !== 0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_first_comma: vcnt=%0d locked=%b, want 0/0", vcnt, locked);
    end
    send_sym(10'h0AA);
    n_tests++;
    if (vcnt !== 0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_data_between: vcnt=%0d locked=%b, want 0/0", vcnt, locked);
    end
    send_sym(10'h283);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || locked !== 1'b1 || out_10b !== 10'h283) begin
      n_fail++;
      $display("FAIL lock_rise: vcnt=%0d vlast=%b locked=%b out=%h, want 1/1/1/283", vcnt, vlast, locked, out_10b);
    end
    send_sym(10'h155);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || locked !== 1'b1 || out_10b !== 10'h155) begin
      n_fail++;
      $display("FAIL lock_next_strobe: vcnt=%0d vlast=%b locked=%b out=%h, want 1/1/1/155", vcnt, vlast, locked, out_10b);
    end
  endtask

  task automatic test_loss_of_lock();
    vcnt = 0;
    send_bit(1'b1);
    send_sym(10'h17C);
    // Old boundary falls on the 9th comma bit: misaligned window emitted, comma counted as a miss.
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b0 || locked !== 1'b1 || out_10b !== 10'h2F9) begin
      n_fail++;
      $display("FAIL unlock_miss1: vcnt=%0d vlast=%b locked=%b out=%h, want 1/0/1/2f9", vcnt, vlast, locked, out_10b);
    end
    send_sym(10'h17C);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b0 || locked !== 1'b0 || out_10b !== 10'h2F8) begin
      n_fail++;
      $display("FAIL unlock_miss2: vcnt=%0d vlast=%b locked=%b out=%h, want 1/0/0/2f8", vcnt, vlast, locked, out_10b);
    end
    send_sym(10'h283);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || locked !== 1'b1 || out_10b !== 10'h283) begin
      n_fail++;
      $display("FAIL relock: vcnt=%0d vlast=%b locked=%b out=%h, want 1/1/1/283", vcnt, vlast, locked, out_10b);
    end
  endtask

  task automatic test_enb_gating();
    logic [9:0] s;
    s = 10'h0AA;
    vcnt = 0;
    for (int i = 0; i < 4; i++) send_bit(s[i]);
    for (int i = 0; i < 7; i++) begin
      ENB = 1'b0;
      in_serial = 1'($urandom);
      @(posedge CLK);
      #1;
      n_tests++;
      if (valid !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL enb_hold cyc%0d: valid=%b locked=%b, want 0/1", i, valid, locked);
      end
    end
    for (int i = 4; i < 10; i++) send_bit(s[i]);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || out_10b !== 10'h0AA) begin
      n_fail++;
      $display("FAIL enb_resume: vcnt=%0d vlast=%b out=%h, want 1/1/0aa", vcnt, vlast, out_10b);
    end
    s = 10'h155;
    vcnt = 0;
    for (int i = 0; i < 3; i++) send_bit(s[i]);
    n_tests++;
    if (vcnt !== 0 || out_10b !== 10'h0AA) begin
      n_fail++;
      $display("FAIL out_hold: vcnt=%0d out=%h, want 0/0aa", vcnt, out_10b);
    end
    for (int i = 3; i < 10; i++) send_bit(s[i]);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || out_10b !== 10'h155) begin
      n_fail++;
      $display("FAIL enb_next_sym: vcnt=%0d vlast=%b out=%h, want 1/1/155", vcnt, vlast, out_10b);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] s;
    s = 10'h0AA;
    for (int i = 0; i < 3; i++) send_bit(s[i]);
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0 || valid !== 1'b0 || out_10b !== 10'h0) begin
      n_fail++;
      $display("FAIL async_clear: locked=%b valid=%b out=%h, want 0/0/000", locked, valid, out_10b);
    end
    ENB = 1'b0;
    @(posedge CLK);
    #1 reset = 1'b1;
    send_sym(10'h17C);
    n_tests++;
    if (vcnt !== 0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_relock_first: vcnt=%0d locked=%b, want 0/0", vcnt, locked);
    end
    send_sym(10'h283);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || locked !== 1'b1 || out_10b !== 10'h283) begin
      n_fail++;
      $display("FAIL async_relock: vcnt=%0d vlast=%b locked=%b out=%h, want 1/1/1/283", vcnt, vlast, locked, out_10b);
    end
  endtask

  task automatic test_rephase();
    do_reset();
    send_sym(10'h17C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_sym(10'h283);
    n_tests++;
    if (vcnt !== 0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rephase_no_lock: vcnt=%0d locked=%b, want 0/0", vcnt, locked);
    end
    send_sym(10'h17C);
    n_tests++;
    if (vcnt !== 1 || vlast !== 1'b1 || locked !== 1'b1 || out_10b !== 10'h17C) begin
      n_fail++;
      $display("FAIL rephase_lock: vcnt=%0d vlast=%b locked=%b out=%h, want 1/1/1/17c", vcnt, vlast, locked, out_10b);
    end
  endtask

  initial begin
    reset = 1'b0; ENB = 1'b0; in_serial = 1'b0;
    vcnt = 0; vlast = 1'b0;
    #2;
    test_reset();
    test_lock();
    test_loss_of_lock();
    test_enb_gating();
    test_async_reset();
    test_rephase();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
